// File: rtl/rd_stream_pkg.sv
// rd_stream_pkg -- shared definitions for the read-side stream adapter.
//   state_t    : buffer occupancy state (EMPTY / ONE / FULL)
//   BEAT_CNT_W : width of the optional accepted-beat counter
package rd_stream_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int BEAT_CNT_W = 32;

endpackage

// File: rtl/rd_stream_adapter.sv
// rd_stream_adapter -- turns the read side of an async FIFO (rempty/rdata/rinc)
// into a valid/ready stream using a 2-entry (head + skid) buffer.
//
// The skid entry means rinc never has to look at m_ready: with one word held
// we can always accept one more, and only a full buffer stops the pop.
//
// Ports
//   rclk      in   read-domain clock
//   rrst_n    in   synchronous active-low reset
//   rempty    in   upstream FIFO empty flag
//   rdata     in   upstream FIFO read data (valid whenever rempty=0)
//   rinc      out  pop strobe to upstream FIFO
//   m_valid   out  downstream valid
//   m_data    out  downstream data
//   m_ready   in   downstream ready
//   beat_cnt  out  accepted-beat counter (only with RD_STREAM_STATS_EN)
//
// Build option: define RD_STREAM_STATS_EN to add the beat_cnt port/counter.
module rd_stream_adapter
  import rd_stream_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready
`ifdef RD_STREAM_STATS_EN
  ,
  output logic [BEAT_CNT_W-1:0] beat_cnt
`endif
);

  state_t           state;
  state_t           state_nx;
  logic [DSIZE-1:0] head;
  logic [DSIZE-1:0] skid;
  logic             push;
  logic             pop;

  assign push   = rinc;
  assign pop    = m_valid && m_ready;
  assign m_data = head;

  // State register and data capture.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        EMPTY: if (push) head <= rdata;
        ONE: begin
          // Head drains while a new word arrives: the new word becomes head.
          if (push && pop)       head <= rdata;
          else if (push && !pop) skid <= rdata;
        end
        FULL:    if (pop) head <= skid;
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   if (push) state_nx = ONE;
      ONE: begin
        if (push && !pop)      state_nx = FULL;
        else if (pop && !push) state_nx = EMPTY;
      end
      FULL:    if (pop) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  // Outputs. rinc looks only at occupancy and rempty, never at m_ready.
  // It is also held low whenever reset is being sampled so the FIFO is
  // not popped into a buffer that is about to be cleared.
  always_comb begin
    rinc    = 1'b0;
    m_valid = 1'b0;
    if (rrst_n && !rempty && (state != FULL)) rinc = 1'b1;
    if (state != EMPTY) m_valid = 1'b1;
  end

`ifdef RD_STREAM_STATS_EN
  logic [BEAT_CNT_W-1:0] beat_cnt_q;

  // Free-running count of accepted beats; wraps naturally.
  always_ff @(posedge rclk) begin
    if (!rrst_n)  beat_cnt_q <= '0;
    else if (pop) beat_cnt_q <= beat_cnt_q + BEAT_CNT_W'(1);
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_rd_stream_adapter.sv
// Directed bench for rd_stream_adapter. The upstream FIFO is a queue that
// pops on every clock edge where rinc was high.
module tb_rd_stream_adapter;
  import rd_stream_pkg::*;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
`ifdef RD_STREAM_STATS_EN
  logic [31:0] beat_cnt;
`endif

  int nerr = 0;
  int nchk = 0;
  logic [7:0] src[$];

  always #5 rclk = ~rclk;

  rd_stream_adapter #(.DSIZE(8)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready)
`ifdef RD_STREAM_STATS_EN
    ,
    .beat_cnt(beat_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic upd();
    rempty = (src.size() == 0);
    rdata  = rempty ? 8'h00 : src[0];
    #1;
  endtask

  // One clock: remember rinc before the edge, pop the source queue if it was set.
  task automatic tick();
    logic r;
    r = rinc;
    @(posedge rclk);
    #1;
    if (r && src.size() > 0) void'(src.pop_front());
    upd();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    // ---------------- reset ----------------
    rrst_n = 1'b0; m_ready = 1'b0;
    src = '{8'h77};
    upd();
    chk("rinc_in_reset", rinc, 0);
    tick();
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_state", 32'(dut.state), 32'(EMPTY));
    chk("rinc_in_reset2", rinc, 0);
`ifdef RD_STREAM_STATS_EN
    chk("rst_cnt", beat_cnt, 0);
`endif
    src.delete(); upd();
    rrst_n = 1'b1;
    tick();

    // ---------------- streaming 0x00..0x0F ----------------
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) src.push_back(8'(i));
    upd();
    chk("stream_rinc", rinc, 1);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("stream_valid%0d", k), m_valid, 1);
      chk($sformatf("stream_data%0d", k), m_data, k);
    end
    tick();
    chk("stream_drained", m_valid, 0);
`ifdef RD_STREAM_STATS_EN
    chk("stream_cnt", beat_cnt, 16);
`endif

    // ---------------- empty ----------------
    for (int k = 0; k < 4; k++) begin
      m_ready = k[0];
      tick();
      chk($sformatf("empty_rinc%0d", k), rinc, 0);
      chk($sformatf("empty_valid%0d", k), m_valid, 0);
    end

    // ---------------- backpressure ----------------
    m_ready = 1'b0;
    src = '{8'hA1, 8'hA2, 8'hA3};
    upd();
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (rinc) pulses++;
      tick();
    end
    chk("bp_pulses", pulses, 2);
    chk("bp_state", 32'(dut.state), 32'(FULL));
    chk("bp_valid", m_valid, 1);
    chk("bp_hold", m_data, 8'hA1);
    chk("bp_rinc_full", rinc, 0);
    m_ready = 1'b1;
    tick();
    chk("bp_out2", m_data, 8'hA2);
    tick();
    chk("bp_out3", m_data, 8'hA3);
    tick();
    chk("bp_done", m_valid, 0);

    // ---------------- push+pop in ONE ----------------
    m_ready = 1'b0;
    src = '{8'h55};
    upd();
    tick();
    chk("pp_state1", 32'(dut.state), 32'(ONE));
    chk("pp_head", m_data, 8'h55);
    src = '{8'h66};
    upd();
    m_ready = 1'b1;
    tick();
    chk("pp_data", m_data, 8'h66);
    chk("pp_state2", 32'(dut.state), 32'(ONE));
    tick();
    chk("pp_done", m_valid, 0);

    // ---------------- reset while FULL ----------------
    m_ready = 1'b0;
    src = '{8'h11, 8'h22, 8'h33};
    upd();
    tick();
    tick();
    chk("rf_state", 32'(dut.state), 32'(FULL));
    rrst_n = 1'b0;
    #1;
    chk("rf_rinc", rinc, 0);
    tick();
    chk("rf_valid", m_valid, 0);
    chk("rf_state2", 32'(dut.state), 32'(EMPTY));
`ifdef RD_STREAM_STATS_EN
    chk("rf_cnt", beat_cnt, 0);
`endif
    rrst_n = 1'b1;
    src = '{8'h44};
    upd();
    m_ready = 1'b1;
    tick();
    chk("rf_next_valid", m_valid, 1);
    chk("rf_next_data", m_data, 8'h44);
    tick();
    chk("rf_done", m_valid, 0);

`ifdef RD_STREAM_STATS_EN
    // ---------------- counter wrap ----------------
    chk("wrap_pre", beat_cnt, 1);
    dut.beat_cnt_q = 32'hFFFF_FFFE;
    src = '{8'h01, 8'h02, 8'h03};
    upd();
    for (int k = 0; k < 4; k++) tick();
    chk("wrap_cnt", beat_cnt, 32'h0000_0001);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
